// File: rtl/phy_reg_freelist_pkg.sv
// Shared sizing, ID/pointer types and popcount helpers for the physical-register free list.
package phy_reg_freelist_pkg;

  localparam int unsigned PHY_REG_NUM  = 64;
  localparam int unsigned ARCH_REG_NUM = 32;
  localparam int unsigned ALLOC_WIDTH  = 4;
  localparam int unsigned FREE_WIDTH   = 4;

  localparam int unsigned PHY_ID_W = $clog2(PHY_REG_NUM);
  localparam int unsigned PTR_W    = PHY_ID_W + 1;
  localparam int unsigned FREE_CAP = PHY_REG_NUM - ARCH_REG_NUM;

  typedef logic [PHY_ID_W-1:0] phy_id_t;
  typedef logic [PTR_W-1:0]    ptr_t;

  function automatic phy_id_t ptr_idx(input ptr_t p);
    return phy_id_t'(p);
  endfunction

  function automatic ptr_t popcount_alloc(input logic [ALLOC_WIDTH-1:0] v);
    ptr_t c;
    c = '0;
    for (int unsigned k = 0; k < ALLOC_WIDTH; k++) c = c + ptr_t'(v[k]);
    return c;
  endfunction

  function automatic ptr_t popcount_free(input logic [FREE_WIDTH-1:0] v);
    ptr_t c;
    c = '0;
    for (int unsigned k = 0; k < FREE_WIDTH; k++) c = c + ptr_t'(v[k]);
    return c;
  endfunction

endpackage

// File: rtl/phy_reg_freelist_if.sv
// Rename/commit <-> free-list signal bundle; master = pipeline side, slave = free list.
interface phy_reg_freelist_if;
  import phy_reg_freelist_pkg::*;

  phy_id_t [ALLOC_WIDTH-1:0] freelist_rename_new_phy_id;
  logic    [ALLOC_WIDTH-1:0] freelist_rename_new_phy_id_valid;
  logic    [ALLOC_WIDTH-1:0] rename_freelist_alloc_valid;
  logic                      rename_freelist_alloc;
  phy_id_t [FREE_WIDTH-1:0]  commit_freelist_free_id;
  logic    [FREE_WIDTH-1:0]  commit_freelist_free_valid;
  logic    [FREE_WIDTH-1:0]  commit_freelist_retire_valid;
  logic                      commit_freelist_flush;
  logic    [PTR_W-1:0]       freelist_free_count;
  logic                      freelist_error;

  modport master (
    input  freelist_rename_new_phy_id, freelist_rename_new_phy_id_valid,
           freelist_free_count, freelist_error,
    output rename_freelist_alloc_valid, rename_freelist_alloc,
           commit_freelist_free_id, commit_freelist_free_valid,
           commit_freelist_retire_valid, commit_freelist_flush
  );

  modport slave (
    output freelist_rename_new_phy_id, freelist_rename_new_phy_id_valid,
           freelist_free_count, freelist_error,
    input  rename_freelist_alloc_valid, rename_freelist_alloc,
           commit_freelist_free_id, commit_freelist_free_valid,
           commit_freelist_retire_valid, commit_freelist_flush
  );
endinterface

// File: rtl/phy_reg_freelist_compactor.sv
// freelist_compactor: maps sparse release channels to contiguous write offsets plus their count.
module freelist_compactor
  import phy_reg_freelist_pkg::*;
(
  input  logic [FREE_WIDTH-1:0] valid,
  output ptr_t [FREE_WIDTH-1:0] offset,
  output ptr_t                  count
);

  ptr_t acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int unsigned k = 0; k < FREE_WIDTH; k++) begin
      offset[k] = acc;
      acc       = acc + ptr_t'(valid[k]);
    end
    count = acc;
  end

endmodule

// File: rtl/phy_reg_freelist.sv
// Physical-register free list with speculative/committed read pointers for one-cycle flush recovery.
// Optional double-free bitmap enabled by defining FREELIST_DOUBLE_FREE_CHECK_EN.
module phy_reg_freelist
  import phy_reg_freelist_pkg::*;
(
  input logic               clk,
  input logic               rst,
  phy_reg_freelist_if.slave fl
);

  phy_id_t entries [PHY_REG_NUM];
  ptr_t    rptr, crptr, wptr;
  logic    error_q;

  ptr_t spec_count, crptr_next, alloc_req, alloc_grant, retire_n;
  ptr_t free_n, push_n, occ, room;
  ptr_t [FREE_WIDTH-1:0] free_off;
  logic alloc_err, free_err, dbl_err;

  assign spec_count = wptr - rptr;

  always_comb begin
    fl.freelist_rename_new_phy_id       = '0;
    fl.freelist_rename_new_phy_id_valid = '0;
    for (int unsigned k = 0; k < ALLOC_WIDTH; k++) begin
      fl.freelist_rename_new_phy_id[k]       = entries[ptr_idx(rptr + ptr_t'(k))];
      fl.freelist_rename_new_phy_id_valid[k] = !rst && (spec_count > ptr_t'(k));
    end
  end

  assign fl.freelist_free_count = rst ? '0 : spec_count;
  assign fl.freelist_error      = error_q;

  freelist_compactor u_compactor (
    .valid  (fl.commit_freelist_free_valid),
    .offset (free_off),
    .count  (free_n)
  );

  // Capacity is judged against the committed pointer after this cycle's retire.
  always_comb begin
    alloc_req   = (fl.rename_freelist_alloc && !fl.commit_freelist_flush)
                  ? popcount_alloc(fl.rename_freelist_alloc_valid) : '0;
    alloc_err   = alloc_req > spec_count;
    alloc_grant = alloc_err ? spec_count : alloc_req;
    retire_n    = popcount_free(fl.commit_freelist_retire_valid);
    crptr_next  = crptr + retire_n;
    occ         = wptr - crptr_next;
    room        = (occ >= ptr_t'(FREE_CAP)) ? '0 : ptr_t'(FREE_CAP) - occ;
    free_err    = free_n > room;
    push_n      = free_err ? room : free_n;
  end

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  logic [PHY_REG_NUM-1:0] in_list, in_list_next;
  ptr_t                   span;

  always_comb begin
    in_list_next = in_list;
    dbl_err      = 1'b0;
    span         = rptr - crptr_next;
    if (fl.commit_freelist_flush) begin
      for (int unsigned i = 0; i < PHY_REG_NUM; i++)
        if (ptr_t'(i) < span) in_list_next[entries[ptr_idx(crptr_next + ptr_t'(i))]] = 1'b1;
    end else begin
      for (int unsigned k = 0; k < ALLOC_WIDTH; k++)
        if (ptr_t'(k) < alloc_grant) in_list_next[entries[ptr_idx(rptr + ptr_t'(k))]] = 1'b0;
    end
    for (int unsigned k = 0; k < FREE_WIDTH; k++) begin
      if (fl.commit_freelist_free_valid[k]) begin
        if (in_list[fl.commit_freelist_free_id[k]]) dbl_err = 1'b1;
        for (int unsigned j = 0; j < k; j++)
          if (fl.commit_freelist_free_valid[j] &&
              fl.commit_freelist_free_id[j] == fl.commit_freelist_free_id[k]) dbl_err = 1'b1;
        if (free_off[k] < room) in_list_next[fl.commit_freelist_free_id[k]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHY_REG_NUM; i++) in_list[i] <= (i >= ARCH_REG_NUM);
    end else begin
      in_list <= in_list_next;
    end
  end
`else
  assign dbl_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHY_REG_NUM; i++)
        entries[i] <= (i < FREE_CAP) ? phy_id_t'(i + ARCH_REG_NUM) : '0;
      rptr    <= '0;
      crptr   <= '0;
      wptr    <= ptr_t'(FREE_CAP);
      error_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < FREE_WIDTH; k++)
        if (fl.commit_freelist_free_valid[k] && (free_off[k] < room))
          entries[ptr_idx(wptr + free_off[k])] <= fl.commit_freelist_free_id[k];
      wptr    <= wptr + push_n;
      crptr   <= crptr_next;
      rptr    <= fl.commit_freelist_flush ? crptr_next : rptr + alloc_grant;
      error_q <= error_q | alloc_err | free_err | dbl_err;
    end
  end

endmodule

// File: tb/tb_phy_reg_freelist.sv
// Directed + randomized bench for phy_reg_freelist against a queue-based free-list model.
module tb_phy_reg_freelist;
  import phy_reg_freelist_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phy_reg_freelist_if fl();
  phy_reg_freelist dut (.clk(clk), .rst(rst), .fl(fl));

  int tests = 0;
  int fails = 0;

  // Model: q holds IDs from the committed head to the tail; the first spec_off are speculatively taken.
  int q[$];
  int pool[$];
  int spec_off;
  bit merr;

  logic       s_alloc, s_flush;
  logic [3:0] s_av, s_fv, s_rv;
  int         s_id[4];

  function automatic int pc(input logic [3:0] v);
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    fl.rename_freelist_alloc        = s_alloc;
    fl.rename_freelist_alloc_valid  = s_av;
    fl.commit_freelist_free_valid   = s_fv;
    fl.commit_freelist_retire_valid = s_rv;
    fl.commit_freelist_flush        = s_flush;
    for (int k = 0; k < 4; k++) fl.commit_freelist_free_id[k] = phy_id_t'(s_id[k]);
  endtask

  task automatic clear_stim();
    s_alloc = 1'b0; s_flush = 1'b0; s_av = '0; s_fv = '0; s_rv = '0;
    for (int k = 0; k < 4; k++) s_id[k] = 0;
  endtask

  task automatic model_reset();
    q.delete(); pool.delete();
    for (int i = 32; i < 64; i++) q.push_back(i);
    for (int i = 0; i < 32; i++) pool.push_back(i);
    spec_off = 0;
    merr = 1'b0;
  endtask

  task automatic model_apply();
    int sc, n, r;
    sc = q.size() - spec_off;
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    for (int k = 0; k < 4; k++) begin
      if (s_fv[k]) begin
        for (int p = spec_off; p < q.size(); p++) if (q[p] == s_id[k]) merr = 1'b1;
        for (int j = 0; j < k; j++) if (s_fv[j] && s_id[j] == s_id[k]) merr = 1'b1;
      end
    end
`endif
    n = (s_alloc && !s_flush) ? pc(s_av) : 0;
    if (n > sc) begin merr = 1'b1; n = sc; end
    spec_off += n;
    r = pc(s_rv);
    for (int i = 0; i < r; i++) pool.push_back(q.pop_front());
    spec_off -= r;
    if (s_flush) spec_off = 0;
    for (int k = 0; k < 4; k++) begin
      if (s_fv[k]) begin
        if (q.size() < int'(FREE_CAP)) q.push_back(s_id[k]);
        else merr = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    int sc;
    sc = q.size() - spec_off;
    chk("free_count", 32'(fl.freelist_free_count), sc);
    chk("error", 32'(fl.freelist_error), 32'(merr));
    for (int k = 0; k < 4; k++) begin
      chk("offer_valid", 32'(fl.freelist_rename_new_phy_id_valid[k]), 32'(k < sc));
      if (k < sc) chk("offer_id", 32'(fl.freelist_rename_new_phy_id[k]), q[spec_off + k]);
    end
  endtask

  task automatic cycle();
    drive();
    model_apply();
    @(posedge clk);
    #1;
    clear_stim();
    drive();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_stim();
    drive();
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(fl.freelist_rename_new_phy_id_valid), 0);
    chk("rst_count", 32'(fl.freelist_free_count), 0);
    chk("rst_error", 32'(fl.freelist_error), 0);
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  task automatic alloc_cycle(input logic [3:0] av);
    s_alloc = 1'b1;
    s_av    = av;
    cycle();
  endtask

  task automatic rand_cycle();
    int sc, r, room, nf, f, idx;
    sc = q.size() - spec_off;
    s_flush = ($urandom_range(0, 15) == 0);
    s_alloc = 1'($urandom_range(0, 1));
    s_av    = 4'($urandom);
    while (pc(s_av) > sc) s_av = s_av & (s_av - 4'd1);
    r = $urandom_range(0, (spec_off < 4) ? spec_off : 4);
    s_rv = '0;
    while (pc(s_rv) < r) s_rv[$urandom_range(0, 3)] = 1'b1;
    room = int'(FREE_CAP) - (q.size() - r);
    nf = (room < pool.size()) ? room : pool.size();
    if (nf > 4) nf = 4;
    f = $urandom_range(0, nf);
    s_fv = '0;
    while (pc(s_fv) < f) s_fv[$urandom_range(0, 3)] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (s_fv[k]) begin
        idx = $urandom_range(0, pool.size() - 1);
        s_id[k] = pool[idx];
        pool.delete(idx);
      end else begin
        s_id[k] = $urandom_range(0, 63);
      end
    end
    cycle();
  endtask

  initial begin
    clear_stim();
    drive();

    // Reset state and first offer
    do_reset();
    for (int k = 0; k < 4; k++) chk("t1_id", 32'(fl.freelist_rename_new_phy_id[k]), 32 + k);
    chk("t1_valid", 32'(fl.freelist_rename_new_phy_id_valid), 32'hF);
    chk("t1_count", 32'(fl.freelist_free_count), 32);

    // Partial allocation
    alloc_cycle(4'b1011);
    for (int k = 0; k < 4; k++) chk("t2_id", 32'(fl.freelist_rename_new_phy_id[k]), 35 + k);
    chk("t2_count", 32'(fl.freelist_free_count), 29);

    // Drain to empty with overflow
    do_reset();
    for (int i = 0; i < 7; i++) alloc_cycle(4'b1111);
    alloc_cycle(4'b0011);
    chk("t3_valid2", 32'(fl.freelist_rename_new_phy_id_valid), 32'h3);
    chk("t3_count2", 32'(fl.freelist_free_count), 2);
    alloc_cycle(4'b1111);
    chk("t3_count0", 32'(fl.freelist_free_count), 0);
    chk("t3_valid0", 32'(fl.freelist_rename_new_phy_id_valid), 0);
    chk("t3_error", 32'(fl.freelist_error), 1);

    // Sparse free with retire, then consume through to the freed IDs
    do_reset();
    alloc_cycle(4'b1111);
    s_fv = 4'b1010; s_id[0] = 17; s_id[1] = 5; s_id[2] = 23; s_id[3] = 9;
    s_rv = 4'b1100;
    cycle();
    chk("t4_count", 32'(fl.freelist_free_count), 30);
    for (int i = 0; i < 6; i++) alloc_cycle(4'b1111);
    chk("t4_last", 32'(fl.freelist_rename_new_phy_id[3]), 63);
    alloc_cycle(4'b1111);
    chk("t4_id0", 32'(fl.freelist_rename_new_phy_id[0]), 5);
    chk("t4_id1", 32'(fl.freelist_rename_new_phy_id[1]), 9);
    chk("t4_valid", 32'(fl.freelist_rename_new_phy_id_valid), 32'h3);

    // Flush restores speculative allocations beyond the committed point
    do_reset();
    alloc_cycle(4'b1111);
    alloc_cycle(4'b1111);
    s_rv = 4'b0011;
    cycle();
    s_flush = 1'b1;
    s_alloc = 1'b1; s_av = 4'b1111;
    cycle();
    for (int k = 0; k < 4; k++) chk("t5_id", 32'(fl.freelist_rename_new_phy_id[k]), 34 + k);
    chk("t5_count", 32'(fl.freelist_free_count), 30);

    // Randomized legal traffic, many pointer wraps
    do_reset();
    for (int i = 0; i < 2000; i++) rand_cycle();

    // Freeing an ID that is still in the list
    do_reset();
    alloc_cycle(4'b1111);
    s_rv = 4'b1111;
    cycle();
    s_fv = 4'b0001; s_id[0] = 40;
    cycle();
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    chk("t6_dbl_err", 32'(fl.freelist_error), 1);
`else
    chk("t6_dbl_err", 32'(fl.freelist_error), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
